muldiv_unit: RTL and testbench

Iterative multi-cycle multiply/divide unit implementing the RV32M operations, sitting beside `alu` in the execute stage. The ALU covers single-cycle integer ops; this block takes the M-extension ops the ALU does not, runs them over 32 iterations, and hands the result back with a start/busy/done handshake. The pipeline control stalls on `busy` and writes `C` to the register file on `done`.

---
 rtl/muldiv_unit.sv | 185 ++++++++++++++++++
 tb/tb_muldiv_unit.sv | 192 +++++++++++++++++++
 2 files changed

// File: rtl/muldiv_unit.sv
// Iterative RV32M multiply/divide unit: 32-cycle shift-add multiply and restoring divide
// on operand magnitudes, with a sign-fix cycle and a start/busy/done handshake.
module muldiv_unit #(
  parameter int unsigned XLEN = 32
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            start,
  input  logic [2:0]      op,
  input  logic [XLEN-1:0] A,
  input  logic [XLEN-1:0] B,
  input  logic            flush,
  output logic            busy,
  output logic            done,
  output logic [XLEN-1:0] C
);

  typedef enum logic [1:0] {
    StIdle,
    StCalc,
    StFix,
    StDone
  } state_e;

  localparam logic [2:0] OpMul    = 3'b000;
  localparam logic [2:0] OpMulh   = 3'b001;
  localparam logic [2:0] OpMulhsu = 3'b010;
  localparam logic [2:0] OpMulhu  = 3'b011;
  localparam logic [2:0] OpDiv    = 3'b100;
  localparam logic [2:0] OpDivu   = 3'b101;
  localparam logic [2:0] OpRem    = 3'b110;
  localparam logic [2:0] OpRemu   = 3'b111;

  state_e              state_q, state_d;
  logic [2:0]          op_q, op_d;
  logic                neg_q, neg_d;
  logic                sign_a_q, sign_a_d;
  logic [5:0]          cnt_q, cnt_d;
  // Multiplicand for multiply, divisor for divide.
  logic [XLEN-1:0]     opnd_q, opnd_d;
  // Product for multiply, {remainder, quotient} for divide.
  logic [2*XLEN-1:0]   acc_q, acc_d;
  logic [XLEN-1:0]     c_q, c_d;

  logic                a_signed, b_signed;
  logic                sign_a_in, sign_b_in;
  logic [XLEN-1:0]     mag_a, mag_b;
  logic                div_by_zero, div_ovf;

  logic [XLEN:0]       mul_sum;
  logic [2*XLEN-1:0]   mul_next;
  logic [2*XLEN-1:0]   div_shift;
  logic [XLEN:0]       div_diff;
  logic [2*XLEN-1:0]   div_next;

  logic [2*XLEN-1:0]   prod_fix;
  logic [XLEN-1:0]     quot_fix;
  logic [XLEN-1:0]     rem_fix;
  logic [XLEN-1:0]     result;

  // Operand decode for the request presented in IDLE.
  always_comb begin
    a_signed    = (op == OpMulh) || (op == OpMulhsu) || (op == OpDiv) || (op == OpRem);
    b_signed    = (op == OpMulh) || (op == OpDiv) || (op == OpRem);
    sign_a_in   = a_signed & A[XLEN-1];
    sign_b_in   = b_signed & B[XLEN-1];
    mag_a       = sign_a_in ? (~A + 1'b1) : A;
    mag_b       = sign_b_in ? (~B + 1'b1) : B;
    div_by_zero = op[2] && (B == '0);
    div_ovf     = op[2] && !op[0] && (A == {1'b1, {(XLEN-1){1'b0}}}) && (B == '1);
  end

  // One iteration of each algorithm.
  always_comb begin
    mul_sum   = {1'b0, acc_q[2*XLEN-1:XLEN]} + (acc_q[0] ? {1'b0, opnd_q} : '0);
    mul_next  = {mul_sum, acc_q[XLEN-1:1]};
    div_shift = {acc_q[2*XLEN-2:0], 1'b0};
    // The bit shifted out of the top keeps the partial remainder 33 bits wide.
    div_diff  = {acc_q[2*XLEN-1], div_shift[2*XLEN-1:XLEN]} - {1'b0, opnd_q};
    div_next  = div_diff[XLEN] ? div_shift
                               : {div_diff[XLEN-1:0], div_shift[XLEN-1:1], 1'b1};
  end

  // Sign correction and result selection.
  always_comb begin
    prod_fix = neg_q ? (~acc_q + 1'b1) : acc_q;
    quot_fix = neg_q ? (~acc_q[XLEN-1:0] + 1'b1) : acc_q[XLEN-1:0];
    rem_fix  = sign_a_q ? (~acc_q[2*XLEN-1:XLEN] + 1'b1) : acc_q[2*XLEN-1:XLEN];
    case (op_q)
      OpMul:                      result = prod_fix[XLEN-1:0];
      OpMulh, OpMulhsu, OpMulhu:  result = prod_fix[2*XLEN-1:XLEN];
      OpDiv, OpDivu:              result = quot_fix;
      OpRem, OpRemu:              result = rem_fix;
      default:                    result = '0;
    endcase
  end

  always_comb begin
    state_d  = state_q;
    op_d     = op_q;
    neg_d    = neg_q;
    sign_a_d = sign_a_q;
    cnt_d    = cnt_q;
    opnd_d   = opnd_q;
    acc_d    = acc_q;
    c_d      = c_q;

    unique case (state_q)
      StIdle: begin
        if (start) begin
          op_d     = op;
          sign_a_d = sign_a_in;
          neg_d    = sign_a_in ^ sign_b_in;
          cnt_d    = '0;
          if (op[2]) begin
            opnd_d = mag_b;
            acc_d  = {{XLEN{1'b0}}, mag_a};
          end else begin
            opnd_d = mag_a;
            acc_d  = {{XLEN{1'b0}}, mag_b};
          end
          if (div_by_zero) begin
            c_d     = op[1] ? A : '1;
            state_d = StDone;
          end else if (div_ovf) begin
            c_d     = op[1] ? '0 : A;
            state_d = StDone;
          end else begin
            state_d = StCalc;
          end
        end
      end
      StCalc: begin
        acc_d = op_q[2] ? div_next : mul_next;
        cnt_d = cnt_q + 6'd1;
        if (cnt_q == 6'd31) begin
          state_d = StFix;
        end
      end
      StFix: begin
        c_d     = result;
        state_d = StDone;
      end
      StDone: begin
        state_d = StIdle;
      end
      default: begin
        state_d = StIdle;
      end
    endcase

    // A kill overrides any transition and leaves the last result untouched.
    if (flush) begin
      state_d = StIdle;
      c_d     = c_q;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= StIdle;
      op_q     <= '0;
      neg_q    <= 1'b0;
      sign_a_q <= 1'b0;
      cnt_q    <= '0;
      opnd_q   <= '0;
      acc_q    <= '0;
      c_q      <= '0;
    end else begin
      state_q  <= state_d;
      op_q     <= op_d;
      neg_q    <= neg_d;
      sign_a_q <= sign_a_d;
      cnt_q    <= cnt_d;
      opnd_q   <= opnd_d;
      acc_q    <= acc_d;
      c_q      <= c_d;
    end
  end

  assign busy = (state_q != StIdle);
  assign done = (state_q == StDone);
  assign C    = c_q;

endmodule

// File: tb/tb_muldiv_unit.sv
// Self-checking bench for muldiv_unit: directed RV32M cases, abort paths and random ops
// compared against an arithmetic reference model.
module tb_muldiv_unit;

  logic        clk = 1'b0;
  logic        rst, start, flush;
  logic [2:0]  op;
  logic [31:0] A, B, C;
  logic        busy, done;

  int vectors     = 0;
  int miscompares = 0;
  logic [31:0] last_c = '0;

  always #5 clk = ~clk;

  muldiv_unit #(.XLEN(32)) dut (
    .clk   (clk),
    .rst   (rst),
    .start (start),
    .op    (op),
    .A     (A),
    .B     (B),
    .flush (flush),
    .busy  (busy),
    .done  (done),
    .C     (C)
  );

  function automatic logic [31:0] ref_result(input logic [2:0] o, input logic [31:0] a,
                                             input logic [31:0] b);
    longint          sa, sb;
    longint unsigned ua, ub;
    logic [63:0]     p;
    logic [31:0]     r;
    logic            ovf;
    sa  = longint'($signed(a));
    sb  = longint'($signed(b));
    ua  = {32'b0, a};
    ub  = {32'b0, b};
    ovf = (a == 32'h8000_0000) && (b == 32'hFFFF_FFFF);
    p   = '0;
    case (o)
      3'd0: begin p = ua * ub; r = p[31:0]; end
      3'd1: begin p = sa * sb; r = p[63:32]; end
      3'd2: begin p = sa * longint'(ub); r = p[63:32]; end
      3'd3: begin p = ua * ub; r = p[63:32]; end
      3'd4: r = (b == 0) ? 32'hFFFF_FFFF : ovf ? a : 32'($signed(a) / $signed(b));
      3'd5: r = (b == 0) ? 32'hFFFF_FFFF : a / b;
      3'd6: r = (b == 0) ? a : ovf ? 32'h0 : 32'($signed(a) % $signed(b));
      default: r = (b == 0) ? a : a % b;
    endcase
    return r;
  endfunction

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    vectors++;
    assert (got === exp)
    else begin
      miscompares++;
      $error("FAIL %s: observed %h expected %h", tag, got, exp);
    end
  endtask

  // Called at a negedge with the unit idle; returns at a negedge with it idle again.
  task automatic run_op(input logic [2:0] o, input logic [31:0] a, input logic [31:0] b,
                        input bit mid_start, input string tag);
    logic [31:0] exp;
    bit          special;
    int          exp_cyc, done_cyc, busy_cnt, done_cnt;
    exp      = ref_result(o, a, b);
    special  = o[2] && ((b == 0) || (!o[0] && a == 32'h8000_0000 && b == 32'hFFFF_FFFF));
    exp_cyc  = special ? 1 : 34;
    done_cyc = 0;
    busy_cnt = 0;
    done_cnt = 0;
    start = 1'b1; op = o; A = a; B = b;
    @(posedge clk);
    for (int cyc = 1; cyc <= 40; cyc++) begin
      @(negedge clk);
      if (cyc == 1) begin
        start = 1'b0; op = 3'($urandom); A = $urandom; B = $urandom;
      end
      if (mid_start && cyc == 10) start = 1'b1;
      if (mid_start && cyc == 11) start = 1'b0;
      if (busy) busy_cnt++;
      if (done) begin
        done_cnt++;
        done_cyc = cyc;
        check({tag, " C"}, C, exp);
      end
      if (!busy) break;
    end
    start = 1'b0;
    check({tag, " done_cycle"}, done_cyc, exp_cyc);
    check({tag, " busy_cycles"}, busy_cnt, exp_cyc);
    check({tag, " done_pulses"}, done_cnt, 32'd1);
    check({tag, " C_held"}, C, exp);
    last_c = exp;
  endtask

  // Starts a normal op and kills it with flush or reset asserted in cycle at_cyc.
  task automatic abort_op(input logic [2:0] o, input logic [31:0] a, input logic [31:0] b,
                          input bit use_rst, input int at_cyc, input string tag);
    int          done_cnt;
    logic [31:0] exp_c;
    done_cnt = 0;
    exp_c    = use_rst ? 32'h0 : last_c;
    start = 1'b1; op = o; A = a; B = b;
    @(posedge clk);
    for (int cyc = 1; cyc <= at_cyc; cyc++) begin
      @(negedge clk);
      if (cyc == 1) start = 1'b0;
      if (done) done_cnt++;
    end
    if (use_rst) rst = 1'b1;
    else flush = 1'b1;
    @(negedge clk);
    rst   = 1'b0;
    flush = 1'b0;
    check({tag, " busy"}, {31'b0, busy}, 32'd0);
    check({tag, " done"}, {31'b0, done}, 32'd0);
    check({tag, " C"}, C, exp_c);
    check({tag, " early_done"}, done_cnt, 32'd0);
    // Make sure nothing completes afterwards either.
    repeat (30) begin
      @(negedge clk);
      if (done) done_cnt++;
    end
    check({tag, " late_done"}, done_cnt, 32'd0);
    check({tag, " C_after"}, C, exp_c);
    last_c = exp_c;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [2:0]  ro;
    logic [31:0] ra, rb;
    rst = 1'b1; start = 1'b0; flush = 1'b0; op = '0; A = '0; B = '0;
    repeat (3) @(negedge clk);
    check("reset busy", {31'b0, busy}, 32'd0);
    check("reset done", {31'b0, done}, 32'd0);
    check("reset C", C, 32'd0);
    rst = 1'b0;
    @(negedge clk);
    check("idle busy", {31'b0, busy}, 32'd0);

    run_op(3'd0, 32'd7, 32'd6, 1'b0, "MUL 7x6");
    run_op(3'd3, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0, "MULHU max");
    run_op(3'd1, 32'h8000_0000, 32'h8000_0000, 1'b0, "MULH min");
    run_op(3'd2, 32'hFFFF_FFFF, 32'd2, 1'b0, "MULHSU -1x2");
    run_op(3'd0, -32'sd3, 32'd5, 1'b0, "MUL -3x5");
    run_op(3'd4, -32'sd7, 32'd2, 1'b0, "DIV -7/2");
    run_op(3'd6, -32'sd7, 32'd2, 1'b0, "REM -7/2");
    run_op(3'd5, 32'd100, 32'd7, 1'b0, "DIVU 100/7");
    run_op(3'd7, 32'd100, 32'd7, 1'b0, "REMU 100/7");
    run_op(3'd4, 32'd5, 32'd0, 1'b0, "DIV 5/0");
    run_op(3'd7, 32'd5, 32'd0, 1'b0, "REMU 5/0");
    run_op(3'd4, 32'h8000_0000, 32'hFFFF_FFFF, 1'b0, "DIV ovf");
    run_op(3'd6, 32'h8000_0000, 32'hFFFF_FFFF, 1'b0, "REM ovf");
    run_op(3'd5, 32'hFFFF_FFFF, 32'h8000_0001, 1'b0, "DIVU big");
    run_op(3'd7, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 1'b0, "REMU big");
    run_op(3'd1, 32'h1234_5678, 32'h9ABC_DEF0, 1'b1, "MULH midstart");

    abort_op(3'd5, 32'd1000, 32'd3, 1'b0, 10, "flush@10");
    run_op(3'd4, 32'd1000, -32'sd3, 1'b0, "DIV after flush");
    abort_op(3'd0, 32'hDEAD_BEEF, 32'h1234_5678, 1'b1, 20, "rst@20");
    run_op(3'd0, 32'hDEAD_BEEF, 32'h1234_5678, 1'b0, "MUL after rst");

    for (int i = 0; i < 40; i++) begin
      ro = 3'($urandom);
      ra = $urandom;
      rb = $urandom;
      case ($urandom_range(0, 7))
        0: rb = 32'h0;
        1: begin ra = 32'h8000_0000; rb = 32'hFFFF_FFFF; end
        2: rb = 32'($urandom_range(1, 15));
        default: ;
      endcase
      run_op(ro, ra, rb, 1'b0, $sformatf("rand%0d op%0d", i, ro));
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
